// File: rtl/framebuffer_reader.sv
// framebuffer_reader: prefetching RGB565 framebuffer scanner feeding a
// display pixel stream expanded to RGB888.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_start         pulse: restart scan at address 0
//   i_pixel_req           display consumes one pixel this cycle
//   o_read_address/enable framebuffer read port
//   i_read_data           RGB565 word, READ_LATENCY cycles after strobe
//   o_rgb888/o_pixel_valid registered expanded pixel
//   o_underflow           registered pulse: request found FIFO empty
module framebuffer_reader #(
  parameter int FRAME_PIXELS = 153600,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_pixel_req,
  output logic [17:0] o_read_address,
  output logic        o_read_enable,
  input  logic [15:0] i_read_data,
  output logic [23:0] o_rgb888,
  output logic        o_pixel_valid,
  output logic        o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [18:0] LP_END = 19'(FRAME_PIXELS);

  // 19 bits so a full 262144-pixel frame can reach its end value
  logic [18:0]             r_rd_addr;
  logic [READ_LATENCY-1:0] r_tags;
  logic [15:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;
  logic [23:0]             r_rgb;
  logic                    r_valid;
  logic                    r_underflow;

  logic [2:0]              w_inflight;
  logic [SW-1:0]           w_used;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_starve;
  logic [READ_LATENCY-1:0] w_tags_next;
  logic [15:0]             w_head;

  function automatic logic [23:0] f_expand(
    input logic [15:0] d
  );
    return {d[15:11], d[15:13],
            d[10:5],  d[10:9],
            d[4:0],   d[4:2]};
  endfunction

  // Every outstanding tag (including the one landing this
  // cycle) holds a FIFO slot, so pushes can never overflow.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + {2'b00, r_tags[i]};
    end
  end

  assign w_used = SW'(r_count) + SW'(w_inflight);

  assign w_issue = !i_rst && !i_frame_start
                && (w_used < SW'(FIFO_DEPTH))
                && (r_rd_addr < LP_END);

  assign w_push = r_tags[READ_LATENCY-1]
               && !i_frame_start;

  // Pop decision uses the registered count, so a word
  // pushed into an empty FIFO pops one cycle later.
  assign w_pop = i_pixel_req && !i_frame_start
              && (r_count != '0);

  assign w_starve = i_pixel_req && !i_frame_start
                 && (r_count == '0);

  assign w_tags_next = (r_tags << 1)
                     | READ_LATENCY'(w_issue);

  assign w_head = r_mem[r_rptr];

  assign o_read_enable  = w_issue;
  assign o_read_address = i_rst ? '0 : r_rd_addr[17:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr <= '0;
    end else if (i_frame_start) begin
      r_rd_addr <= '0;
    end else if (w_issue) begin
      r_rd_addr <= r_rd_addr + 19'(1);
    end
  end

  // Clearing tags on restart drops returns of stale reads.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_tags <= '0;
    end else begin
      r_tags <= w_tags_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wptr] <= i_read_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // o_rgb888 holds while idle; an underflow forces it to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb       <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_pop) begin
      r_rgb       <= f_expand(w_head);
      r_valid     <= 1'b1;
      r_underflow <= 1'b0;
    end else if (w_starve) begin
      r_rgb       <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b1;
    end else begin
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end
  end

  assign o_rgb888      = r_rgb;
  assign o_pixel_valid = r_valid;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: directed bench for framebuffer_reader
// with a latency-2 RAM model and a 16-pixel frame.
module tb_framebuffer_reader;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        req;
  logic [17:0] addr;
  logic        en;
  logic [15:0] rdata;
  logic [23:0] rgb;
  logic        valid;
  logic        uf;

  logic [15:0] ram [32];
  logic [15:0] d1;
  logic [15:0] d2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads = 0;
  int max_addr = 0;
  int base;
  logic [17:0] alog [256];

  framebuffer_reader #(
    .FRAME_PIXELS(16),
    .READ_LATENCY(2),
    .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_frame_start(fs),
    .i_pixel_req(req),
    .o_read_address(addr),
    .o_read_enable(en),
    .i_read_data(rdata),
    .o_rgb888(rgb),
    .o_pixel_valid(valid),
    .o_underflow(uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= ram[addr[4:0]];
    d2 <= d1;
  end
  assign rdata = d2;

  always @(negedge clk) begin
    if (en) begin
      alog[n_reads[7:0]] = addr;
      n_reads = n_reads + 1;
      if (int'(addr) > max_addr) max_addr = int'(addr);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // small words: only blue is non-zero
  function automatic logic [31:0] blue(input int k);
    return 32'((k << 3) | (k >> 2));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fs  = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = 16'(i);
    step();
    step();
    check("rst_en", en, 0);
    check("rst_addr", addr, 0);
    check("rst_rgb", rgb, 0);
    check("rst_valid", valid, 0);
    check("rst_uf", uf, 0);

    // prefetch straight out of reset
    base = n_reads;
    rst = 1'b0;
    #1;
    check("rel_en", en, 1);
    check("rel_addr", addr, 0);
    repeat (20) step();
    check("fill_reads", n_reads - base, 8);
    check("fill_idle", en, 0);
    for (int k = 0; k < 8; k++)
      check("fill_addr", alog[8'(base + k)], k);

    // stream through end of frame into underflow
    req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k < 16) begin
        check("str_valid", valid, 1);
        check("str_rgb", rgb, blue(k));
        check("str_uf", uf, 0);
      end else begin
        check("uf_valid", valid, 0);
        check("uf_pulse", uf, 1);
        check("uf_rgb", rgb, 0);
      end
    end
    req = 1'b0;
    step();
    check("idle_valid", valid, 0);
    check("idle_uf", uf, 0);
    check("idle_rgb", rgb, 0);
    check("frame_reads", n_reads - base, 16);
    check("max_addr", max_addr, 15);
    check("end_en", en, 0);

    // expansion of primary colours and grey
    ram[0] = 16'hF81F;
    ram[1] = 16'h07E0;
    ram[2] = 16'h8410;
    fs = 1'b1;
    step();
    fs = 1'b0;
    repeat (12) step();
    req = 1'b1;
    step();
    check("exp_mag", rgb, 32'hFF00FF);
    step();
    check("exp_grn", rgb, 32'h00FF00);
    step();
    check("exp_gry", rgb, 32'h848284);
    req = 1'b0;
    step();
    check("hold_valid", valid, 0);
    check("hold_rgb", rgb, 32'h848284);

    // restart with count 5 and 2 reads in flight
    fs = 1'b1;
    step();
    fs = 1'b0;
    #1;
    check("rs_en", en, 1);
    check("rs_addr", addr, 0);
    repeat (7) step();
    check("c8_en", en, 1);
    check("c8_addr", addr, 7);
    fs  = 1'b1;
    req = 1'b1;
    #1;
    check("fs_gate", en, 0);
    step();
    fs  = 1'b0;
    req = 1'b0;
    #1;
    check("fsreq_valid", valid, 0);
    check("fsreq_uf", uf, 0);
    check("rs2_en", en, 1);
    check("rs2_addr", addr, 0);
    repeat (12) step();
    req = 1'b1;
    step();
    check("rs_p0", rgb, 32'hFF00FF);
    step();
    check("rs_p1", rgb, 32'h00FF00);
    step();
    check("rs_p2", rgb, 32'h848284);
    step();
    check("rs_p3", rgb, blue(3));
    req = 1'b0;

    // reset in the middle of streaming
    repeat (10) step();
    req = 1'b1;
    repeat (5) step();
    check("pre_valid", valid, 1);
    rst = 1'b1;
    #1;
    check("mr_en", en, 0);
    step();
    check("mr_rgb", rgb, 0);
    check("mr_valid", valid, 0);
    check("mr_uf", uf, 0);
    check("mr_addr", addr, 0);
    rst = 1'b0;
    req = 1'b0;
    base = n_reads;
    #1;
    check("mr_en1", en, 1);
    check("mr_addr1", addr, 0);
    repeat (12) step();
    check("mr_reads", n_reads - base, 8);
    req = 1'b1;
    step();
    check("mr_p0", rgb, 32'hFF00FF);
    step();
    check("mr_p1", rgb, 32'h00FF00);
    req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
